// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and the op-select enumeration.
// Used by both the encoder and the decode side.
package riscv_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_SLT  = 4'd5,
        OP_ADDI = 4'd6,
        OP_ANDI = 4'd7,
        OP_ORI  = 4'd8,
        OP_SLTI = 4'd9,
        OP_LW   = 4'd10,
        OP_SW   = 4'd11,
        OP_BEQ  = 4'd12,
        OP_JAL  = 4'd13,
        OP_LUI  = 4'd14,
        OP_ILL  = 4'd15
    } op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // True when v is a sign-extension of its bits [msb:0].
    function automatic logic sext_fits(input logic [31:0] v, input logic [4:0] msb);
        logic [31:0] hi;
        hi = v >> msb;
        return (hi == 32'd0) || (hi == (32'hFFFF_FFFF >> msb));
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with immediate legality check.
// Produces a zero word whenever the request is illegal.
module instr_pack
    import riscv_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    op_e  op_s;
    logic fit12;
    logic fit13;
    logic fit21;

    assign op_s  = op_e'(op);
    assign fit12 = sext_fits(imm, 5'd11);
    assign fit13 = sext_fits(imm, 5'd12);
    assign fit21 = sext_fits(imm, 5'd20);

    always_comb begin
        word    = 32'd0;
        illegal = 1'b0;
        unique case (op_s)
            OP_ADD:
                word = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_SUB:
                word = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_OP};
            OP_SLL:
                word = {F7_BASE, rs2, rs1, F3_SLL, rd, OPC_OP};
            OP_AND:
                word = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_OP};
            OP_OR:
                word = {F7_BASE, rs2, rs1, F3_OR, rd, OPC_OP};
            OP_SLT:
                word = {F7_BASE, rs2, rs1, F3_SLT, rd, OPC_OP};
            OP_ADDI: begin
                illegal = !fit12;
                word    = {imm[11:0], rs1, F3_ADD, rd, OPC_OPIMM};
            end
            OP_ANDI: begin
                illegal = !fit12;
                word    = {imm[11:0], rs1, F3_AND, rd, OPC_OPIMM};
            end
            OP_ORI: begin
                illegal = !fit12;
                word    = {imm[11:0], rs1, F3_OR, rd, OPC_OPIMM};
            end
            OP_SLTI: begin
                illegal = !fit12;
                word    = {imm[11:0], rs1, F3_SLT, rd, OPC_OPIMM};
            end
            OP_LW: begin
                illegal = !fit12;
                word    = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
            end
            OP_SW: begin
                illegal = !fit12;
                word    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
            end
            OP_BEQ: begin
                illegal = !fit13 || imm[0];
                word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                           imm[4:1], imm[11], OPC_BRANCH};
            end
            OP_JAL: begin
                illegal = !fit21 || imm[0];
                word    = {imm[20], imm[10:1], imm[11], imm[19:12],
                           rd, OPC_JAL};
            end
            OP_LUI: begin
                illegal = (imm[31:20] != 12'd0);
                word    = {imm[19:0], rd, OPC_LUI};
            end
            OP_ILL:
                illegal = 1'b1;
            default:
                illegal = 1'b1;
        endcase
        if (illegal) begin
            word = 32'd0;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: one-entry output register feeding an instruction-memory
// writer, with a byte-address counter and a saturating reject counter.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_data,
    output logic              err,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [31:0] pack_word;
    logic        pack_ill;
    logic        accept;
    logic        fire;

    instr_pack u_pack (
        .op      (in_op),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .word    (pack_word),
        .illegal (pack_ill)
    );

    // Soft clear and reset both block acceptance for the cycle.
    assign in_ready = !reset && !clr && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (clr) begin
            out_valid_d = 1'b0;
            out_data_d  = 32'd0;
            out_addr_d  = '0;
            cnt_d       = '0;
            err_cnt_d   = 8'd0;
        end else begin
            if (fire) begin
                cnt_d       = cnt_q + ADDR_STEP;
                out_valid_d = 1'b0;
            end
            if (accept && !pack_ill) begin
                out_valid_d = 1'b1;
                out_data_d  = pack_word;
                out_addr_d  = cnt_d;
            end
            if (accept && pack_ill) begin
                err_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_addr_q  <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;
    assign err_count = err_cnt_q;

endmodule
